// File: rtl/ser_pkg.sv
// Shared definitions for the 1-bit serial link (serializer and deserializer).
// The bit-count "mod" encoding lives here so both ends agree on it.
package ser_pkg;

  localparam int SER_DATA_W = 16;
  localparam int SER_MOD_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } ser_rx_state_t;

  // A full word (SER_DATA_W bits) is encoded as 0; shorter counts pass through.
  function automatic logic [SER_MOD_W-1:0] mod_encode(input logic [SER_MOD_W-1:0] count);
    return {1'b0, count[SER_MOD_W-2:0]};
  endfunction

endpackage

// File: rtl/ser_deserializer.sv
// Receive side of the 1-bit serial link: rebuilds MSB-first frames into a
// left-aligned word plus bit count, with one data_val_o strobe per frame.
module ser_deserializer
  import ser_pkg::*;
#(
  parameter int DATA_W = SER_DATA_W,
  parameter int MOD_W  = SER_MOD_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ser_data_i,
  input  logic              ser_busy_i,
  output logic [DATA_W-1:0] data_o,
  output logic [MOD_W-1:0]  data_mod_o,
  output logic              data_val_o,
  output logic              err_o,
  output logic              busy_o
);

  // Handshake: no backpressure. data_o/data_mod_o/err_o are valid only in the
  // single cycle data_val_o is high; the consumer must take them then.
  localparam logic [MOD_W-1:0]  FULL_CNT = MOD_W'(DATA_W);
  localparam logic [DATA_W-1:0] ZERO_W   = '0;

  ser_rx_state_t     state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [MOD_W-1:0]  cnt_q,   cnt_d;
  logic              ovf_q,   ovf_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [MOD_W-1:0]  mod_q,   mod_d;
  logic              err_q,   err_d;
  logic              val_q,   val_d;
  logic [DATA_W-1:0] bit_at_msb;

  assign bit_at_msb = {ser_data_i, ZERO_W[DATA_W-2:0]};

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    mod_d   = mod_q;
    err_d   = err_q;
    val_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ser_busy_i) begin
          shift_d = bit_at_msb;
          cnt_d   = MOD_W'(1);
          ovf_d   = 1'b0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (ser_busy_i) begin
          // Shifting the MSB-placed bit right by the count lands it at DATA_W-1-cnt.
          if (cnt_q < FULL_CNT) begin
            shift_d = shift_q | (bit_at_msb >> cnt_q);
            cnt_d   = cnt_q + MOD_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          data_d  = shift_q;
          mod_d   = mod_encode(cnt_q);
          err_d   = ovf_q;
          val_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      mod_q   <= '0;
      err_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      err_q   <= err_d;
      val_q   <= val_d;
    end
  end

  // busy_o is the registered FSM state and doubles as its debug view.
  assign busy_o     = (state_q == RECV);
  assign data_o     = data_q;
  assign data_mod_o = mod_q;
  assign err_o      = err_q;
  assign data_val_o = val_q;

endmodule

// File: tb/tb_ser_deserializer.sv
// Bench for ser_deserializer: directed frames plus a closed loop against a
// behavioural serializer, checked through an expected-result queue.
module tb_ser_deserializer;

  localparam int DATA_W = 16;
  localparam int MOD_W  = 5;
  localparam int W      = DATA_W + MOD_W + 1;

  logic              clk;
  logic              rst;
  logic              ser_data;
  logic              ser_busy;
  logic [DATA_W-1:0] data_o;
  logic [MOD_W-1:0]  data_mod_o;
  logic              data_val_o;
  logic              err_o;
  logic              busy_o;

  int n_vec;
  int n_err;
  int n_strobe;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ser_deserializer #(.DATA_W(DATA_W), .MOD_W(MOD_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ser_data_i (ser_data),
    .ser_busy_i (ser_busy),
    .data_o     (data_o),
    .data_mod_o (data_mod_o),
    .data_val_o (data_val_o),
    .err_o      (err_o),
    .busy_o     (busy_o)
  );

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && data_val_o) begin
      logic [W-1:0] e;
      n_strobe++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("data", 32'(data_o), 32'(e[W-1 -: DATA_W]));
        check_val("mod", 32'(data_mod_o), 32'(e[MOD_W:1]));
        check_val("err", 32'(err_o), 32'(e[0]));
      end
    end
  end

  // ---------------- drivers ----------------
  function automatic logic [W-1:0] model_frame(input logic [31:0] bits, input int n);
    logic [DATA_W-1:0] d;
    logic [MOD_W-1:0]  m;
    d = '0;
    for (int i = 0; i < n && i < DATA_W; i++) d[DATA_W-1-i] = bits[n-1-i];
    m = (n >= DATA_W) ? '0 : MOD_W'(n);
    return {d, m, (n > DATA_W)};
  endfunction

  // bits[n-1] goes out first; gap cycles of busy low follow the frame.
  task automatic send_frame(input logic [31:0] bits, input int n, input int gap, input bit push);
    if (push) exp_q.push_back(model_frame(bits, n));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ser_busy = 1'b1;
      ser_data = bits[n-1-i];
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      ser_busy = 1'b0;
      ser_data = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    logic [DATA_W-1:0] word, mask, ones;
    int mod_i, n, wait_cnt;
    n_vec = 0; n_err = 0; n_strobe = 0;
    rst = 1'b1; ser_busy = 1'b0; ser_data = 1'b0;
    ones = '1;
    repeat (3) @(negedge clk);
    check_val("rst_data", 32'(data_o), 32'd0);
    check_val("rst_mod", 32'(data_mod_o), 32'd0);
    check_val("rst_val", 32'(data_val_o), 32'd0);
    check_val("rst_err", 32'(err_o), 32'd0);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full 16-bit frame with explicit latency and strobe-width checks.
    send_frame(32'hA5C3, 16, 0, 1'b1);
    @(negedge clk);
    ser_busy = 1'b0;
    check_val("lat_busy_during", 32'(busy_o), 32'd1);
    check_val("lat_val_early", 32'(data_val_o), 32'd0);
    @(negedge clk);
    check_val("lat_val_on", 32'(data_val_o), 32'd1);
    check_val("lat_busy_end", 32'(busy_o), 32'd0);
    @(negedge clk);
    check_val("lat_val_one_cycle", 32'(data_val_o), 32'd0);
    check_val("hold_data", 32'(data_o), 32'hA5C3);
    repeat (2) @(negedge clk);

    send_frame(32'b1011, 4, 3, 1'b1);
    send_frame({16'hFFFF, 2'b00}, 18, 3, 1'b1);
    send_frame(32'b111, 3, 1, 1'b1);
    send_frame(32'b01010, 5, 3, 1'b1);
    send_frame(32'b1, 1, 1, 1'b1);
    send_frame(32'b0, 1, 1, 1'b1);
    send_frame(32'h0001_2345, 17, 1, 1'b1);
    send_frame(32'h8001, 16, 2, 1'b1);

    // Reset after 7 bits: partial frame vanishes, trailing bits form a new frame.
    send_frame(32'b1101101, 7, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1; ser_busy = 1'b1; ser_data = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_mid_busy", 32'(busy_o), 32'd0);
    check_val("rst_mid_val", 32'(data_val_o), 32'd0);
    exp_q.push_back(model_frame(32'b101, 3));
    ser_busy = 1'b1; ser_data = 1'b1;
    @(negedge clk); ser_data = 1'b0;
    @(negedge clk); ser_data = 1'b1;
    @(negedge clk); ser_busy = 1'b0;
    repeat (3) @(negedge clk);

    // Closed loop: behavioural serializer sends the top mod bits of each word.
    for (int k = 0; k < 1000; k++) begin
      word  = DATA_W'($urandom_range(0, 65535));
      mod_i = $urandom_range(0, DATA_W - 1);
      n     = (mod_i == 0) ? DATA_W : mod_i;
      mask  = ~(ones >> n);
      exp_q.push_back({word & mask, MOD_W'(mod_i), 1'b0});
      send_frame(32'(word) >> (DATA_W - n), n, $urandom_range(1, 3), 1'b0);
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    check_val("strobe_count", 32'(n_strobe), 32'd1010);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ser_deserializer.md
Name: ser_deserializer

Overview:
- Receive side of the 1-bit serial link driven by the team's serializer block (ser_data_o / busy_o).
- Collects the bits shifted out MSB-first while the link's busy signal is high.
- Rebuilds the parallel word, left-aligned, together with its bit count in the same 5-bit "mod" encoding the serializer takes as input (0 means full 16 bits).
- Sits at the far end of the link in the lab top-level and feeds a checker or downstream logic with one valid pulse per frame.

Parameters:
- DATA_W, 16, parallel word width; bits arrive MSB-first.
- MOD_W, 5, width of the bit-count field; must equal $clog2(DATA_W)+1.

Ports:
- clk_i  in  1  single clock, all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ser_data_i  in  1  serial data bit; valid in every cycle where ser_busy_i=1.
- ser_busy_i  in  1  frame qualifier; high for exactly one cycle per transmitted bit, contiguous within a frame.
- data_o  out  DATA_W  received word, MSB = first bit, unreceived LSBs zero.
- data_mod_o  out  MOD_W  bits received in the frame; DATA_W encoded as 0.
- data_val_o  out  1  one-cycle strobe qualifying data_o, data_mod_o and err_o.
- err_o  out  1  frame had more than DATA_W bits; qualified by data_val_o.
- busy_o  out  1  high while a frame is being collected.

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE, shift register 0, bit counter 0, data_o 0, data_mod_o 0, data_val_o 0, err_o 0, busy_o 0. Reset mid-frame discards the partial frame; no data_val_o is produced for it.
- FSM has two states, IDLE and RECV.
- IDLE:
  - ser_busy_i=1: shift register loads {ser_data_i, zeros} (bit placed at MSB), counter=1, overflow flag=0, go to RECV.
  - ser_busy_i=0: stay in IDLE.
- RECV with ser_busy_i=1:
  - counter<DATA_W: place ser_data_i at bit position DATA_W-1-counter, counter+1.
  - counter=DATA_W: bit discarded, overflow flag=1. The counter saturates at DATA_W and never wraps.
- RECV with ser_busy_i=0 (frame end): at this edge, register outputs and go to IDLE:
  - data_o = shift register.
  - data_mod_o = counter mod 2**(MOD_W-1); 16 bits gives 0.
  - err_o = overflow flag.
  - data_val_o=1.
- Latency: data_val_o is high in the cycle after the first cycle in which ser_busy_i is low. The last bit is sampled at edge N, the end is detected at edge N+1, and data_val_o is high during the cycle after edge N+1.
- data_val_o lasts exactly one cycle. data_o, data_mod_o and err_o hold their values until the next frame end or reset.
- busy_o = (state==RECV), registered.
- Back-to-back frames: a single low cycle of ser_busy_i is a valid gap.
  - If ser_busy_i rises at the edge right after the end edge, the new frame starts from IDLE normally.
  - That start edge and the previous frame's data_val_o cycle may coincide; both must be handled with no loss.
- Minimum frame is 1 bit: data_mod_o=1, data_o={bit,15'b0}.
- No backpressure. The consumer must take data in the data_val_o cycle.

Decomposition:
- Package ser_pkg holds:
  - DATA_W and MOD_W localparam defaults.
  - typedef enum logic {IDLE, RECV} ser_rx_state_t.
  - a function mod_encode(count) returning count mod 2**(MOD_W-1).
- The serializer shares the same package so the mod encoding is defined in one place.
- No sub-module: the FSM, counter and shift register stay in one module of about 150 lines.

Test Plan:
- 16-bit frame carrying 0xA5C3 MSB-first, busy high 16 cycles → data_o=0xA5C3, data_mod_o=0, err_o=0, data_val_o one cycle, 2 edges after the last bit.
- 4-bit frame 1,0,1,1 → data_o=0xB000, data_mod_o=4, err_o=0.
- 18-bit frame: first 16 bits 0xFFFF, then 0,0 → data_o=0xFFFF, data_mod_o=0, err_o=1.
- Frames 3 bits 1,1,1 and 5 bits 0,1,0,1,0 separated by a single idle cycle → two strobes:
  - first: data_o=0xE000, data_mod_o=3.
  - second: data_o=0x5000, data_mod_o=5.
- rst_i asserted for 1 cycle after 7 bits of a frame, busy stays high 3 more cycles → no data_val_o for that frame. Because the FSM is in IDLE after reset, the 3 remaining busy-high bits are collected as a new 3-bit frame, giving one strobe with data_mod_o=3. busy_o=0 in the cycle after the reset edge.
- Closed loop with the serializer DUT, 1000 random data_i/data_mod_i words → every valid word is received as data_i masked to its top data_mod bits, and data_mod_o equals data_mod_i.
